inst_fetch: RTL and testbench

//  Fetch stage feeding the instruction decoder. Owns the PC and drives a synchronous

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_queue.sv | 74 +++++++
 rtl/inst_fetch.sv | 98 +++++++++
 tb/tb_inst_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: word widths and the fetch
// control states.
package cpu_pkg;

  localparam int INST_W     = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {instr, pc} FIFO between the imem response and the decoder.
// The head entry lives in dedicated registers that drive the decoder outputs.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [INST_W-1:0] wr_instr,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic              rd_en,
  output logic [1:0]        count,
  output logic              valid,
  output logic [INST_W-1:0] head_instr,
  output logic [ADDR_W-1:0] head_pc
);

  typedef struct packed {
    logic [INST_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t head;
  entry_t tail;
  entry_t wr_entry;
  logic   rd;
  logic   tail_we;

  assign wr_entry   = '{instr: wr_instr, pc: wr_pc};
  assign rd         = rd_en && (count != 2'd0);
  assign valid      = (count != 2'd0);
  assign head_instr = head.instr;
  assign head_pc    = head.pc;

  // The head only moves on a dequeue or when filling an empty queue, so the
  // decoder sees a stable word for as long as it stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (rd && !wr_en) begin
      if (count == 2'd2) begin
        head  <= tail;
        count <= 2'd1;
      end else begin
        count <= 2'd0;
      end
    end else if (wr_en && !rd) begin
      if (count == 2'd0) begin
        head  <= wr_entry;
        count <= 2'd1;
      end else if (count == 2'd1) begin
        count <= 2'd2;
      end
    end else if (wr_en && rd) begin
      head <= (count == 2'd2) ? tail : wr_entry;
    end
  end

  assign tail_we = wr_en && !flush &&
                   (((count == 2'd1) && !rd) || ((count == 2'd2) && rd));

  // NOTE: tail storage has no reset; count alone says whether it holds data,
  // so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (tail_we) tail <= wr_entry;
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle synchronous imem and
// hands {instrm, pc_out} to the decoder through a 2-entry queue.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] instrm,
  output logic [ADDR_W-1:0] pc_out,
  output logic              inst_valid,
  input  logic              inst_ready
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [1:0]        q_count;
  logic [1:0]        occ;
  logic              deq;
  logic              seq_ok;

  assign deq = inst_valid && inst_ready;
  assign occ = q_count + {1'b0, inflight};

  // NOTE: every output of this block gets a default first so no path through
  // the case/if leaves a value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    seq_ok    = 1'b0;
    imem_en   = 1'b0;
    imem_addr = redirect_valid ? redirect_pc : pc;

    case (state)
      IDLE, HALT: if (start && !halt) state_nxt = RUN;
      RUN:        if (halt) state_nxt = HALT;
      default:    state_nxt = IDLE;
    endcase

    // Room for one more word counting the in-flight read; a full pipe may
    // still issue when the decoder frees a slot this cycle.
    seq_ok  = (occ < 2'd2) || ((occ == 2'd2) && deq);
    imem_en = (state == RUN) && (redirect_valid || seq_ok);

    if (redirect_valid) begin
      pc_nxt = (state == RUN) ? redirect_pc + STEP : redirect_pc;
    end else if (imem_en) begin
      pc_nxt = pc + STEP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= imem_en;
      if (imem_en) inflight_pc <= imem_addr;
    end
  end

  // A redirect flushes the queue and drops the response of the read issued
  // last cycle; only the redirect target's read survives.
  fetch_queue #(.ADDR_W(ADDR_W)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .wr_en     (inflight && !redirect_valid),
    .wr_instr  (imem_rdata),
    .wr_pc     (inflight_pc),
    .rd_en     (deq),
    .count     (q_count),
    .valid     (inst_valid),
    .head_instr(instrm),
    .head_pc   (pc_out)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: imem model returning addr+0x100 and a
// scoreboard of expected PCs consumed on every decoder handshake.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instrm;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        mon_en   = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .halt          (halt),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instrm        (instrm),
    .pc_out        (pc_out),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready)
  );

  // Synchronous instruction memory, 1-cycle latency, mem[a] = a + 0x100.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr + 32'h100;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each accepted word must be the next expected PC; a redirect
  // discards the rest of the expected stream after this cycle's handshake.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (inst_valid && inst_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("sb_pc", pc_out, e);
          check("sb_instr", instrm, e + 32'h100);
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        push_seq(redirect_pc, 64);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Pulse start, then check first issue and first valid word 2 edges after RUN.
  task automatic start_and_check_first(input string tag, input logic [31:0] first_pc);
    start = 1'b1;
    @(negedge clk);
    check({tag, "_en_before_run"}, 32'(imem_en), 32'd0);
    cyc();
    start = 1'b0;
    @(negedge clk);
    check({tag, "_first_en"}, 32'(imem_en), 32'd1);
    check({tag, "_first_addr"}, imem_addr, first_pc);
    cyc();
    @(negedge clk);
    check({tag, "_valid_t1"}, 32'(inst_valid), 32'd0);
    cyc();
    @(negedge clk);
    check({tag, "_valid_t2"}, 32'(inst_valid), 32'd1);
    check({tag, "_first_pc"}, pc_out, first_pc);
  endtask

  task automatic stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      @(negedge clk);
      check(tag, 32'(inst_valid), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_instrm", instrm, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_imem_en", 32'(imem_en), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_issue", 32'(imem_en), 32'd0);

    // 1. Start and stream at full rate.
    cyc();
    push_seq(32'd0, 64);
    mon_en = 1'b1;
    start_and_check_first("t1", 32'd0);
    stream("t1_stream", 10);

    // 2. Decoder stall: head frozen, nothing issued, no overflow.
    cyc();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_no_issue", 32'(imem_en), 32'd0);
      check("t2_hold_pc", pc_out, exp_q[0]);
      check("t2_hold_instr", instrm, exp_q[0] + 32'h100);
      if (i < 4) cyc();
    end
    cyc();
    inst_ready = 1'b1;
    @(negedge clk);
    check("t2_release_valid", 32'(inst_valid), 32'd1);
    stream("t2_stream", 6);

    // 3. Redirect while the queue is full.
    cyc();
    inst_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    check("t3_redir_en", 32'(imem_en), 32'd1);
    check("t3_redir_addr", imem_addr, 32'h40);
    cyc();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    check("t3_bubble", 32'(inst_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("t3_target_pc", pc_out, 32'h40);
    stream("t3_stream", 4);

    // 4. Redirect in the same cycle as a handshake.
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    check("t4_hs_valid", 32'(inst_valid), 32'd1);
    check("t4_redir_addr", imem_addr, 32'h40);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_bubble", 32'(inst_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("t4_target_pc", pc_out, 32'h40);
    stream("t4_stream", 4);

    // 5. Halt drains queue and in-flight word, then start resumes in sequence.
    cyc();
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_halt_no_issue", 32'(imem_en), 32'd0);
      cyc();
    end
    @(negedge clk);
    check("t5_drained", 32'(inst_valid), 32'd0);
    cyc();
    start_and_check_first("t5", exp_q[0]);
    stream("t5_stream", 5);

    // 6. Reset mid-stream with the decoder stalled.
    cyc();
    inst_ready = 1'b0;
    repeat (3) cyc();
    mon_en = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(inst_valid), 32'd0);
    check("t6_pc_out", pc_out, 32'd0);
    check("t6_instrm", instrm, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t6_idle_no_issue", 32'(imem_en), 32'd0);
      cyc();
      @(negedge clk);
    end
    cyc();
    exp_q.delete();
    push_seq(32'd0, 64);
    inst_ready = 1'b1;
    mon_en = 1'b1;
    start_and_check_first("t6", 32'd0);
    stream("t6_stream", 4);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
